// File: rtl/gpac_adc_word_serializer.sv
// ---------------------------------------------------------------------------
// gpac_adc_word_serializer
//
// Takes 32-bit words from the GPAC ADC receiver FIFO, which is
// first-word-fall-through. It sends each word as four bytes on a valid/ready
// byte stream toward the readout link. The block pops one word for every
// four bytes it sends. When bytes are accepted every cycle, consecutive words
// are sent back-to-back with no gap between them.
//
// Parameters
//   MSB_FIRST   1: bytes go out [31:24],[23:16],[15:8],[7:0]; 0: reversed
//   EXP_HEADER  expected word[31:28], used only by the header filter
//
// Ports
//   BUS_CLK      in   single clock, rising edge
//   BUS_RST_N    in   asynchronous active-low reset
//   ENABLE       in   1: pop new words; 0: finish current word, then idle
//   FIFO_EMPTY   in   upstream FIFO empty
//   FIFO_DATA    in   upstream head word (valid while FIFO_EMPTY=0)
//   FIFO_READ    out  pop strobe, combinational, one word per high cycle
//   BYTE_DATA    out  output byte
//   BYTE_VALID   out  BYTE_DATA valid
//   BYTE_READY   in   sink accepts when BYTE_VALID & BYTE_READY
//   WORD_CNT     out  words fully sent, wraps at 2^32
//   HDR_ERR_CNT  out  dropped words, saturating; 0 without the filter
//   BUSY         out  a word is being held
//
// Build option
//   ADC_SER_HEADER_CHECK_EN: when this macro is defined, a word whose
//   [31:28] field does not equal EXP_HEADER is still popped, but it is not
//   sent, and HDR_ERR_CNT is incremented.
// ---------------------------------------------------------------------------
module gpac_adc_word_serializer #(
  parameter bit         MSB_FIRST  = 1'b1,
  parameter logic [3:0] EXP_HEADER = 4'h0
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ,
  output logic [7:0]  BYTE_DATA,
  output logic        BYTE_VALID,
  input  logic        BYTE_READY,
  output logic [31:0] WORD_CNT,
  output logic [15:0] HDR_ERR_CNT,
  output logic        BUSY
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] shift_reg;
  logic [1:0]  byte_idx;
  logic [31:0] word_cnt;
  logic [31:0] load_word;
  logic        accept;
  logic        last_accept;
  logic        load;
  logic        hdr_ok;

  // The word is stored already in output order, so the current byte is
  // always the top byte of the shift register. This keeps BYTE_DATA a plain
  // register output.
  assign load_word = MSB_FIRST ? FIFO_DATA
                               : {FIFO_DATA[7:0], FIFO_DATA[15:8],
                                  FIFO_DATA[23:16], FIFO_DATA[31:24]};

`ifdef ADC_SER_HEADER_CHECK_EN
  assign hdr_ok = (FIFO_DATA[31:28] == EXP_HEADER);
`else
  logic unused_exp_header;
  assign unused_exp_header = ^EXP_HEADER;
  assign hdr_ok = 1'b1;
`endif

  // A new word may be taken while idle. It may also be taken during the
  // cycle in which the last byte of the current word is accepted; that case
  // is what gives one byte per cycle across word boundaries. The reset term
  // forces the pop strobe low while reset is held.
  always_comb begin
    accept      = (state == SEND) && BYTE_READY;
    last_accept = accept && (byte_idx == 2'd3);
    load        = BUS_RST_N && ENABLE && !FIFO_EMPTY &&
                  ((state == IDLE) || last_accept);
  end

  assign FIFO_READ  = load;
  assign BYTE_DATA  = shift_reg[31:24];
  assign BYTE_VALID = (state == SEND);
  assign BUSY       = (state == SEND);
  assign WORD_CNT   = word_cnt;

  // The word load is written after the byte-accept update, so it takes
  // priority when both happen on the same edge (back-to-back words). A word
  // that is dropped by the header filter does not load, so the FSM stays in
  // IDLE or returns to it.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= IDLE;
      shift_reg <= 32'h0;
      byte_idx  <= 2'd0;
      word_cnt  <= 32'h0;
    end else begin
      if (accept) begin
        shift_reg <= {shift_reg[23:0], 8'h00};
        byte_idx  <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word_cnt <= word_cnt + 32'd1;
          state    <= IDLE;
        end
      end
      if (load && hdr_ok) begin
        shift_reg <= load_word;
        byte_idx  <= 2'd0;
        state     <= SEND;
      end
    end
  end

`ifdef ADC_SER_HEADER_CHECK_EN
  logic [15:0] hdr_err_cnt;

  // Dropped-word counter; it holds at all-ones instead of wrapping.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      hdr_err_cnt <= 16'h0;
    end else if (load && !hdr_ok && (hdr_err_cnt != 16'hFFFF)) begin
      hdr_err_cnt <= hdr_err_cnt + 16'd1;
    end
  end

  assign HDR_ERR_CNT = hdr_err_cnt;
`else
  assign HDR_ERR_CNT = 16'h0;
`endif

endmodule

// File: tb/tb_gpac_adc_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_gpac_adc_word_serializer
//
// This bench drives two serializer instances with the same inputs: one
// built MSB-first and one built LSB-first. A byte-queue reference model
// predicts, for every cycle, the byte stream, the pop strobe and the
// counters. It also covers a table of directed vectors, hand-written
// sequences, and a randomized run.
// ---------------------------------------------------------------------------
module tb_gpac_adc_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        byte_ready;

  logic        fifo_read,  lsb_read;
  logic [7:0]  byte_data,  lsb_data;
  logic        byte_valid, lsb_valid;
  logic [31:0] word_cnt,   lsb_word_cnt;
  logic [15:0] hdr_err,    lsb_hdr_err;
  logic        busy,       lsb_busy;

  always #5 clk = ~clk;

  gpac_adc_word_serializer #(.MSB_FIRST(1'b1), .EXP_HEADER(4'h0)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .ENABLE(enable),
    .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_READ(fifo_read),
    .BYTE_DATA(byte_data), .BYTE_VALID(byte_valid), .BYTE_READY(byte_ready),
    .WORD_CNT(word_cnt), .HDR_ERR_CNT(hdr_err), .BUSY(busy)
  );

  gpac_adc_word_serializer #(.MSB_FIRST(1'b0), .EXP_HEADER(4'h0)) dut_lsb (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .ENABLE(enable),
    .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_READ(lsb_read),
    .BYTE_DATA(lsb_data), .BYTE_VALID(lsb_valid), .BYTE_READY(byte_ready),
    .WORD_CNT(lsb_word_cnt), .HDR_ERR_CNT(lsb_hdr_err), .BUSY(lsb_busy)
  );

  // The upstream FIFO contents and the reference model state.
  logic [31:0] fifo_q[$];
  logic [7:0]  mq[$];
  logic [7:0]  lq[$];
  logic [31:0] m_words;
  logic [15:0] m_hdr;
  bit          pop_pending;

  int vectors;
  int miscompares;
  int dut_pops;

  // Values observed during the most recent applyStimulus call.
  logic       obs_valid;
  logic [7:0] obs_byte;
  logic [7:0] obs_lsb;
  logic       obs_read;

  typedef struct {
    bit          push;
    logic [31:0] word;
    bit          en;
    bit          rdy;
    bit          exp_read;
    bit          exp_valid;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit push, logic [31:0] word, bit en, bit rdy,
                              bit er, bit ev, logic [7:0] eb);
    vec_t v;
    v.push = push; v.word = word; v.en = en; v.rdy = rdy;
    v.exp_read = er; v.exp_valid = ev; v.exp_byte = eb;
    return v;
  endfunction

  function automatic bit hdrOk(input logic [31:0] w);
`ifdef ADC_SER_HEADER_CHECK_EN
    return (w[31:28] == 4'h0);
`else
    return (w[31:28] == w[31:28]);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveFifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
  endtask

  // Waits for the next falling edge, then applies the pop that the previous
  // rising edge performed.
  task automatic syncEdge();
    @(negedge clk);
    if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
  endtask

  task automatic checkModel();
    checkOutput("byte_valid", byte_valid, mq.size() != 0);
    checkOutput("busy", busy, mq.size() != 0);
    checkOutput("lsb_byte_valid", lsb_valid, lq.size() != 0);
    if (mq.size() != 0) checkOutput("byte_data", byte_data, mq[0]);
    if (lq.size() != 0) checkOutput("lsb_byte_data", lsb_data, lq[0]);
    checkOutput("word_cnt", word_cnt, m_words);
    checkOutput("lsb_word_cnt", lsb_word_cnt, m_words);
    checkOutput("hdr_err_cnt", hdr_err, m_hdr);
  endtask

  // One clock cycle. The task first checks the registered outputs left by
  // the last edge. It then drives the inputs, checks the pop strobe, and
  // advances the model across the coming rising edge.
  task automatic applyStimulus(input bit en, input bit rdy);
    bit          exp_load;
    logic [31:0] w;
    syncEdge();
    checkModel();
    obs_valid  = byte_valid;
    obs_byte   = byte_data;
    obs_lsb    = lsb_data;
    enable     = en;
    byte_ready = rdy;
    driveFifo();
    #1;
    exp_load = en && (fifo_q.size() != 0) &&
               ((mq.size() == 0) || ((mq.size() == 1) && rdy));
    checkOutput("fifo_read", fifo_read, exp_load);
    checkOutput("lsb_fifo_read", lsb_read, exp_load);
    obs_read = fifo_read;
    if (fifo_read) dut_pops++;
    if (rdy && mq.size() != 0) begin
      void'(mq.pop_front());
      void'(lq.pop_front());
      if (mq.size() == 0) m_words = m_words + 32'd1;
    end
    if (exp_load) begin
      w = fifo_q[0];
      if (hdrOk(w)) begin
        mq.push_back(w[31:24]); mq.push_back(w[23:16]);
        mq.push_back(w[15:8]);  mq.push_back(w[7:0]);
        lq.push_back(w[7:0]);   lq.push_back(w[15:8]);
        lq.push_back(w[23:16]); lq.push_back(w[31:24]);
      end else if (m_hdr != 16'hFFFF) begin
        m_hdr = m_hdr + 16'd1;
      end
    end
    pop_pending = exp_load;
  endtask

  // Asserts reset asynchronously, checks that the outputs clear at once and
  // that no pop is requested, then releases reset with ENABLE low.
  task automatic resetDut(input bit en_during);
    syncEdge();
    rst_n  = 1'b0;
    enable = en_during;
    driveFifo();
    #1;
    checkOutput("rst_byte_valid", byte_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_byte_data", byte_data, 0);
    checkOutput("rst_fifo_read", fifo_read, 0);
    checkOutput("rst_word_cnt", word_cnt, 0);
    checkOutput("rst_hdr_err_cnt", hdr_err, 0);
    mq.delete();
    lq.delete();
    m_words = 32'h0;
    m_hdr   = 16'h0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] got[$];
  logic [7:0] want[$];
  int         pops0;

  task automatic compareBytes(input string name);
    checkOutput({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++)
      checkOutput(name, got[i], want[i]);
  endtask

  initial begin
    vectors = 0; miscompares = 0; dut_pops = 0;
    rst_n = 1'b0; enable = 1'b0; byte_ready = 1'b0;
    pop_pending = 1'b0; m_words = 0; m_hdr = 0;
    driveFifo();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset with a word waiting, then stream it");
    fifo_q.push_back(32'hA1B2C3D4);
    resetDut(1'b1);
    got.delete(); pops0 = dut_pops;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (obs_valid) got.push_back(obs_byte);
    end
`ifdef ADC_SER_HEADER_CHECK_EN
    want = '{};
    checkOutput("t1_word_cnt", word_cnt, 0);
`else
    want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    checkOutput("t1_word_cnt", word_cnt, 1);
`endif
    compareBytes("t1_byte");
    checkOutput("t1_pops", dut_pops - pops0, 1);

    $display("[TB] directed vector table");
    resetDut(1'b0);
    fifo_q.push_back(32'h01020304);
    fifo_q.push_back(32'h05060708);
    fifo_q.push_back(32'h090A0B0C);
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h01));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h02));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h03));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 8'h04));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h05));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h06));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h07));
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 8'h08));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h09));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h0A));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h0B));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h0C));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 32'h0EADBEEF, 1, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'h0E));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'hAD));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'hAD));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'hBE));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'hBE));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 8'hEF));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 8'hEF));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 8'h00));
    pops0 = dut_pops;
    foreach (tbl[i]) begin
      if (tbl[i].push) fifo_q.push_back(tbl[i].word);
      applyStimulus(tbl[i].en, tbl[i].rdy);
      checkOutput("tbl_valid", obs_valid, tbl[i].exp_valid);
      checkOutput("tbl_read", obs_read, tbl[i].exp_read);
      if (tbl[i].exp_valid) checkOutput("tbl_byte", obs_byte, tbl[i].exp_byte);
    end
    checkOutput("tbl_pops", dut_pops - pops0, 4);
    checkOutput("tbl_word_cnt", word_cnt, 4);

    $display("[TB] LSB-first byte order");
    resetDut(1'b0);
    fifo_q.push_back(32'h11223344);
    got.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (obs_valid) got.push_back(obs_lsb);
    end
`ifdef ADC_SER_HEADER_CHECK_EN
    want = '{};
`else
    want = '{8'h44, 8'h33, 8'h22, 8'h11};
`endif
    compareBytes("t4_lsb_byte");

    $display("[TB] enable dropped mid-word");
    resetDut(1'b0);
    fifo_q.push_back(32'h0A0B0C0D);
    fifo_q.push_back(32'h01234567);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    pops0 = dut_pops;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("t5_pops_while_disabled", dut_pops - pops0, 0);
    checkOutput("t5_word_cnt", word_cnt, 1);
    checkOutput("t5_idle", byte_valid, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_resume_read", obs_read, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] header filter");
    resetDut(1'b0);
    fifo_q.push_back(32'h10000001);
    fifo_q.push_back(32'h00000002);
    got.delete(); pops0 = dut_pops;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (obs_valid) got.push_back(obs_byte);
    end
`ifdef ADC_SER_HEADER_CHECK_EN
    want = '{8'h00, 8'h00, 8'h00, 8'h02};
    checkOutput("t6_hdr_err_cnt", hdr_err, 1);
    checkOutput("t6_word_cnt", word_cnt, 1);
`else
    want = '{8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    checkOutput("t6_hdr_err_cnt", hdr_err, 0);
    checkOutput("t6_word_cnt", word_cnt, 2);
`endif
    compareBytes("t6_byte");
    checkOutput("t6_pops", dut_pops - pops0, 2);

    $display("[TB] reset in the middle of a word");
    resetDut(1'b0);
    fifo_q.push_back(32'h0555AAAA);
    fifo_q.push_back(32'h0777BBBB);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    resetDut(1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_mid_first_byte", obs_byte, 8'h07);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) begin
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:28] = 4'h0;
        fifo_q.push_back(w);
      end
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
